// File: rtl/set_count_pkg.sv
// Shared mode encodings, FSM state type and width helpers for the set point-counting engine.
package set_count_pkg;

  localparam logic [2:0] MODE_SINGLE = 3'd0;
  localparam logic [2:0] MODE_UNION  = 3'd1;
  localparam logic [2:0] MODE_ONE    = 3'd2;
  localparam logic [2:0] MODE_TWO    = 3'd3;
  localparam logic [2:0] MODE_ALL    = 3'd4;
  localparam logic [2:0] MODE_LUT    = 3'd5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StScan  = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Squared-distance width: two squares of signed (coord_w+1)-bit differences plus a carry.
  function automatic int unsigned sq_width(input int unsigned coord_w);
    return 2 * coord_w + 3;
  endfunction

  function automatic int unsigned clog2_u(input int unsigned val);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < val) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/circle_member.sv
// Combinational test of whether lattice point (x,y) lies inside or on circle (cx,cy,r).
module circle_member
  import set_count_pkg::*;
#(
  parameter int unsigned COORD_W = 4
) (
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [COORD_W-1:0] i_cx,
  input  logic [COORD_W-1:0] i_cy,
  input  logic [COORD_W-1:0] i_r,
  output logic               o_member
);

  localparam int unsigned SqW = sq_width(COORD_W);

  logic signed [COORD_W:0] w_dx;
  logic signed [COORD_W:0] w_dy;
  logic signed [SqW-1:0]   w_dx_ext;
  logic signed [SqW-1:0]   w_dy_ext;
  logic        [SqW-1:0]   w_dist2;
  logic        [SqW-1:0]   w_r2;

  assign w_dx     = $signed({1'b0, i_x}) - $signed({1'b0, i_cx});
  assign w_dy     = $signed({1'b0, i_y}) - $signed({1'b0, i_cy});
  assign w_dx_ext = SqW'(w_dx);
  assign w_dy_ext = SqW'(w_dy);
  assign w_dist2  = $unsigned(w_dx_ext * w_dx_ext) + $unsigned(w_dy_ext * w_dy_ext);
  assign w_r2     = SqW'(i_r) * SqW'(i_r);
  assign o_member = (w_dist2 <= w_r2);

endmodule

// File: rtl/set_count_multi.sv
// Scans a GRID x GRID lattice LANES points per cycle and counts points meeting the selected
// set predicate over NUM_CIRCLES latched circles.
module set_count_multi
  import set_count_pkg::*;
#(
  parameter int unsigned NUM_CIRCLES = 3,
  parameter int unsigned COORD_W     = 4,
  parameter int unsigned GRID        = 8,
  parameter int unsigned LANES       = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [NUM_CIRCLES*2*COORD_W-1:0] central,
  input  logic [NUM_CIRCLES*COORD_W-1:0]   radius,
  input  logic [2:0]                       mode,
  input  logic [(1<<NUM_CIRCLES)-1:0]      lut,
  output logic                             busy,
  output logic                             valid,
  output logic [CNT_W-1:0]                 candidate
);

  localparam int unsigned NumPts = GRID * GRID;
  localparam int unsigned PtW    = clog2_u(NumPts + 1);
  localparam int unsigned LutW   = 1 << NUM_CIRCLES;

  state_e                                r_state;
  state_e                                w_state_nxt;
  logic [NUM_CIRCLES*2*COORD_W-1:0]      r_central;
  logic [NUM_CIRCLES*COORD_W-1:0]        r_radius;
  logic [2:0]                            r_mode;
  logic [LutW-1:0]                       r_lut;
  logic [PtW-1:0]                        r_pt;
  logic                                  r_mem_vld;
  logic [LANES-1:0][NUM_CIRCLES-1:0]     r_mem;
  logic [LANES-1:0][NUM_CIRCLES-1:0]     w_mem;
  logic [CNT_W-1:0]                      r_acc;
  logic [CNT_W-1:0]                      r_candidate;
  logic [CNT_W-1:0]                      w_grp_cnt;
  logic [CNT_W-1:0]                      w_acc_sum;
  logic [LANES-1:0][COORD_W-1:0]         w_x;
  logic [LANES-1:0][COORD_W-1:0]         w_y;
  logic [NUM_CIRCLES-1:0][COORD_W-1:0]   w_cx;
  logic [NUM_CIRCLES-1:0][COORD_W-1:0]   w_cy;
  logic [NUM_CIRCLES-1:0][COORD_W-1:0]   w_r;
  logic [LANES-1:0]                      w_pred;
  logic                                  w_start;
  logic                                  w_last_grp;

  // DONE accepts a new start so back-to-back jobs have no idle gap.
  assign w_start    = en && ((r_state == StIdle) || (r_state == StDone));
  assign w_last_grp = (r_pt == PtW'(NumPts - LANES));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (w_start) w_state_nxt = StScan;
      StScan:  if (w_last_grp) w_state_nxt = StDrain;
      StDrain: w_state_nxt = StDone;
      StDone:  w_state_nxt = w_start ? StScan : StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Row-major lattice walk: x varies fastest, both axes start at 1.
  always_comb begin
    w_x = '0;
    w_y = '0;
    for (int k = 0; k < LANES; k++) begin
      w_x[k] = COORD_W'((32'(r_pt) + 32'(k)) % GRID + 1);
      w_y[k] = COORD_W'((32'(r_pt) + 32'(k)) / GRID + 1);
    end
  end

  for (genvar i = 0; i < NUM_CIRCLES; i++) begin : g_circ
    localparam int unsigned Base = (NUM_CIRCLES - 1 - i) * 2 * COORD_W;
    assign w_cx[i] = r_central[Base+COORD_W +: COORD_W];
    assign w_cy[i] = r_central[Base +: COORD_W];
    assign w_r[i]  = r_radius[(NUM_CIRCLES-1-i)*COORD_W +: COORD_W];
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    for (genvar i = 0; i < NUM_CIRCLES; i++) begin : g_member
      circle_member #(
        .COORD_W (COORD_W)
      ) u_member (
        .i_x      (w_x[k]),
        .i_y      (w_y[k]),
        .i_cx     (w_cx[i]),
        .i_cy     (w_cy[i]),
        .i_r      (w_r[i]),
        .o_member (w_mem[k][i])
      );
    end
  end

  always_comb begin
    w_pred    = '0;
    w_grp_cnt = '0;
    for (int k = 0; k < LANES; k++) begin
      case (r_mode)
        MODE_SINGLE: w_pred[k] = r_mem[k][0];
        MODE_UNION:  w_pred[k] = |r_mem[k];
        MODE_ONE:    w_pred[k] = ($countones(r_mem[k]) == 1);
        MODE_TWO:    w_pred[k] = ($countones(r_mem[k]) == 2);
        MODE_ALL:    w_pred[k] = &r_mem[k];
        MODE_LUT:    w_pred[k] = r_lut[r_mem[k]];
        default:     w_pred[k] = 1'b0;
      endcase
      w_grp_cnt = w_grp_cnt + CNT_W'(w_pred[k]);
    end
  end

  assign w_acc_sum = r_acc + w_grp_cnt;

  // r_mem_vld masks the stale membership word seen in the first scan cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_central   <= '0;
      r_radius    <= '0;
      r_mode      <= '0;
      r_lut       <= '0;
      r_pt        <= '0;
      r_mem_vld   <= 1'b0;
      r_mem       <= '0;
      r_acc       <= '0;
      r_candidate <= '0;
    end else if (w_start) begin
      r_central <= central;
      r_radius  <= radius;
      r_mode    <= mode;
      r_lut     <= lut;
      r_pt      <= '0;
      r_acc     <= '0;
      r_mem_vld <= 1'b0;
    end else if (r_state == StScan) begin
      r_mem     <= w_mem;
      r_mem_vld <= 1'b1;
      r_pt      <= r_pt + PtW'(LANES);
      if (r_mem_vld) r_acc <= w_acc_sum;
    end else if (r_state == StDrain) begin
      r_acc       <= w_acc_sum;
      r_candidate <= w_acc_sum;
      r_mem_vld   <= 1'b0;
    end
  end

  assign busy      = (r_state == StScan) || (r_state == StDrain);
  assign valid     = (r_state == StDone);
  assign candidate = r_candidate;

endmodule

// File: tb/tb_set_count_multi.sv
// Directed bench for set_count_multi: one LANES=1 and one LANES=4 instance on a shared clock.
module tb_set_count_multi;
  import set_count_pkg::*;

  localparam logic [23:0] C_ONE = {4'd4, 4'd4, 16'd0};
  localparam logic [11:0] R_ONE = {4'd2, 8'd0};
  localparam logic [23:0] C_TWO = {4'd4, 4'd4, 4'd6, 4'd4, 8'd0};
  localparam logic [11:0] R_TWO = {4'd2, 4'd2, 4'd0};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en0 = 1'b0;
  logic        en1 = 1'b0;
  logic [23:0] central;
  logic [11:0] radius;
  logic [2:0]  mode;
  logic [7:0]  lut;
  logic        busy0, valid0, busy1, valid1;
  logic [7:0]  cand0, cand1;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          saw;

  always #5 clk = ~clk;

  set_count_multi #(
    .NUM_CIRCLES (3), .COORD_W (4), .GRID (8), .LANES (1), .CNT_W (8)
  ) u_dut_l1 (
    .clk (clk), .rst (rst), .en (en0), .central (central), .radius (radius),
    .mode (mode), .lut (lut), .busy (busy0), .valid (valid0), .candidate (cand0)
  );

  set_count_multi #(
    .NUM_CIRCLES (3), .COORD_W (4), .GRID (8), .LANES (4), .CNT_W (8)
  ) u_dut_l4 (
    .clk (clk), .rst (rst), .en (en1), .central (central), .radius (radius),
    .mode (mode), .lut (lut), .busy (busy1), .valid (valid1), .candidate (cand1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Operands are scrambled right after the accepting edge; only latched values may matter.
  task automatic start_job(input int sel, input logic [23:0] c, input logic [11:0] r,
                           input logic [2:0] m, input logic [7:0] l);
    @(negedge clk);
    central = c; radius = r; mode = m; lut = l;
    if (sel == 0) en0 = 1'b1; else en1 = 1'b1;
    @(posedge clk);
    #1;
    en0 = 1'b0; en1 = 1'b0;
    central = '1; radius = '1; mode = 3'd6; lut = '1;
  endtask

  task automatic wait_result(input int sel, input string tag, input int exp_cnt,
                             input int exp_lat, input int pulse_at, input bit chain,
                             input logic [23:0] nc, input logic [11:0] nr,
                             input logic [2:0] nm, input logic [7:0] nl);
    int   lat;
    bit   seen;
    logic v;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      v = (sel == 0) ? valid0 : valid1;
      if (lat == 0) begin
        check({tag, "_busy_rise"}, (sel == 0) ? busy0 : busy1, 1);
        check({tag, "_valid_low"}, v, 0);
      end
      if (v) begin
        seen = 1'b1;
        check({tag, "_count"}, (sel == 0) ? cand0 : cand1, exp_cnt);
        check({tag, "_busy_done"}, (sel == 0) ? busy0 : busy1, 0);
        if (chain) begin
          central = nc; radius = nr; mode = nm; lut = nl;
          if (sel == 0) en0 = 1'b1; else en1 = 1'b1;
        end
      end else if (lat == pulse_at) begin
        central = C_ONE; radius = R_ONE; mode = MODE_ALL; lut = 8'h00;
        if (sel == 0) en0 = 1'b1; else en1 = 1'b1;
      end
      @(posedge clk);
      lat++;
      #1;
      en0 = 1'b0; en1 = 1'b0;
    end
    check({tag, "_latency"}, seen ? lat : -1, exp_lat);
    if (!chain) begin
      @(negedge clk);
      check({tag, "_valid_pulse"}, (sel == 0) ? valid0 : valid1, 0);
      check({tag, "_hold"}, (sel == 0) ? cand0 : cand1, exp_cnt);
    end
  endtask

  task automatic run(input int sel, input string tag, input logic [23:0] c,
                     input logic [11:0] r, input logic [2:0] m, input logic [7:0] l,
                     input int exp_cnt, input int exp_lat, input int pulse_at);
    start_job(sel, c, r, m, l);
    wait_result(sel, tag, exp_cnt, exp_lat, pulse_at, 1'b0, '0, '0, '0, '0);
  endtask

  initial begin
    central = '0; radius = '0; mode = '0; lut = '0;
    repeat (3) @(negedge clk);
    check("reset_busy0", busy0, 0);
    check("reset_valid0", valid0, 0);
    check("reset_cand0", cand0, 0);
    check("reset_busy1", busy1, 0);
    check("reset_valid1", valid1, 0);
    check("reset_cand1", cand1, 0);
    rst = 1'b1;

    run(0, "single", C_ONE, R_ONE, MODE_SINGLE, 8'h00, 13, 66, -1);
    run(0, "union", C_TWO, R_TWO, MODE_UNION, 8'h00, 21, 66, -1);
    run(0, "one", C_TWO, R_TWO, MODE_ONE, 8'h00, 16, 66, -1);
    run(0, "two", C_TWO, R_TWO, MODE_TWO, 8'h00, 5, 66, -1);
    run(0, "all", C_TWO, R_TWO, MODE_ALL, 8'h00, 0, 66, -1);
    run(0, "lut", C_TWO, R_TWO, MODE_LUT, 8'b0000_1000, 5, 66, -1);
    run(0, "reserved", C_TWO, R_TWO, 3'd6, 8'hFF, 0, 66, -1);
    run(0, "r15", C_ONE, {4'd15, 8'd0}, MODE_SINGLE, 8'h00, 64, 66, -1);
    run(0, "corner_r0", {4'd1, 4'd1, 16'd0}, 12'd0, MODE_SINGLE, 8'h00, 1, 66, -1);
    run(0, "disabled", 24'd0, 12'd0, MODE_SINGLE, 8'h00, 0, 66, -1);
    run(0, "off_grid", {4'd9, 4'd4, 16'd0}, {4'd1, 8'd0}, MODE_SINGLE, 8'h00, 1, 66, -1);

    run(1, "l4_union", C_TWO, R_TWO, MODE_UNION, 8'h00, 21, 18, -1);
    run(1, "l4_pulse", C_TWO, R_TWO, MODE_UNION, 8'h00, 21, 18, 5);

    start_job(1, C_TWO, R_TWO, MODE_UNION, 8'h00);
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_busy", busy1, 0);
    check("rst_valid", valid1, 0);
    check("rst_cand", cand1, 0);
    check("rst_cand_l1", cand0, 0);
    @(negedge clk);
    rst = 1'b1;
    saw = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (valid1) saw = 1'b1;
    end
    check("rst_no_valid", saw, 0);
    run(1, "l4_after_rst", C_TWO, R_TWO, MODE_UNION, 8'h00, 21, 18, -1);

    start_job(0, C_TWO, R_TWO, MODE_UNION, 8'h00);
    wait_result(0, "b2b_first", 21, 66, -1, 1'b1,
                {4'd1, 4'd1, 16'd0}, 12'd0, MODE_SINGLE, 8'h00);
    wait_result(0, "b2b_second", 1, 66, -1, 1'b0, '0, '0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
